// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA timing generator slice.
//   - Default 640x480 timing constants (25 MHz pixel clock, 800x525 total).
//   - Sync polarity encodings (the level a sync pin takes while asserted).
//   - cnt_width(): counter width able to hold 0..n-1.
package vga_timing_pkg;

  localparam int DEF_VIDEO_WIDTH = 3;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_H_FP        = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_V_FP        = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam int DEF_PIPE_DELAY  = 2;

  localparam int DEF_TOTAL_COLS = DEF_ACTIVE_COLS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_TOTAL_ROWS = DEF_ACTIVE_ROWS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Width of a counter that runs 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Bundle between the render logic and the VGA timing generator.
//   master modport : the timing generator (takes pixel tick, pattern select
//                    and renderer RGB; drives counts, frame pulse, syncs,
//                    data-enable and blanked RGB).
//   slave modport  : the render side / pin driver.
// COL_W / ROW_W must match the generator's counter widths.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int VIDEO_WIDTH = DEF_VIDEO_WIDTH,
  parameter int COL_W       = cnt_width(DEF_TOTAL_COLS),
  parameter int ROW_W       = cnt_width(DEF_TOTAL_ROWS)
);

  logic                   i_Pix_En;
  logic                   i_Pattern_Sel;
  logic [VIDEO_WIDTH-1:0] i_Red_Video;
  logic [VIDEO_WIDTH-1:0] i_Grn_Video;
  logic [VIDEO_WIDTH-1:0] i_Blu_Video;
  logic [COL_W-1:0]       o_Col_Count;
  logic [ROW_W-1:0]       o_Row_Count;
  logic                   o_Frame_Start;
  logic                   o_HSync;
  logic                   o_VSync;
  logic                   o_Active;
  logic [VIDEO_WIDTH-1:0] o_Red_Video;
  logic [VIDEO_WIDTH-1:0] o_Grn_Video;
  logic [VIDEO_WIDTH-1:0] o_Blu_Video;

  modport master (
    input  i_Pix_En, i_Pattern_Sel, i_Red_Video, i_Grn_Video, i_Blu_Video,
    output o_Col_Count, o_Row_Count, o_Frame_Start, o_HSync, o_VSync,
           o_Active, o_Red_Video, o_Grn_Video, o_Blu_Video
  );

  modport slave (
    output i_Pix_En, i_Pattern_Sel, i_Red_Video, i_Grn_Video, i_Blu_Video,
    input  o_Col_Count, o_Row_Count, o_Frame_Start, o_HSync, o_VSync,
           o_Active, o_Red_Video, o_Grn_Video, o_Blu_Video
  );

endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line
// Enable-gated shift register of WIDTH bits by DEPTH stages.
//   clk, rst_n : clock, asynchronous active-low reset (all stages clear to 0)
//   en         : shift strobe; stages hold while low
//   din, dout  : data in / data out DEPTH enabled shifts later
// DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_reg [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (en) begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA timing generator with a pixel-enable-gated delay line so
// syncs, data-enable and blanked RGB line up with a renderer of known latency.
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   bus (master)   : i_Pix_En tick, i_Pattern_Sel, i_*_Video in;
//                    o_Col/Row_Count, o_Frame_Start, o_HSync, o_VSync,
//                    o_Active, o_*_Video out
// All outputs at counts c describe pixel c-PIPE_DELAY (PIPE_DELAY 0..15).
// Optional build macro VGA_TIMING_PATTERN_EN adds an 8-bar colour test
// pattern selectable with i_Pattern_Sel; without it i_Pattern_Sel is ignored.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   VIDEO_WIDTH = DEF_VIDEO_WIDTH,
  parameter int   ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic H_SYNC_POL  = SYNC_ACTIVE_LOW,
  parameter logic V_SYNC_POL  = SYNC_ACTIVE_LOW,
  parameter int   PIPE_DELAY  = DEF_PIPE_DELAY
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  vga_timing_gen_if.master bus
);

  localparam int TOTAL_COLS = ACTIVE_COLS + H_FP + H_SYNC + H_BP;
  localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FP + V_SYNC + V_BP;
  localparam int COL_W      = cnt_width(TOTAL_COLS);
  localparam int ROW_W      = cnt_width(TOTAL_ROWS);
  localparam int RGB_W      = 3 * VIDEO_WIDTH;

  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [COL_W-1:0] H_ACT_END   = COL_W'(ACTIVE_COLS);
  localparam logic [ROW_W-1:0] V_ACT_END   = ROW_W'(ACTIVE_ROWS);
  localparam logic [COL_W-1:0] H_SYNC_BEG  = COL_W'(ACTIVE_COLS + H_FP);
  localparam logic [COL_W-1:0] H_SYNC_LAST = COL_W'(ACTIVE_COLS + H_FP + H_SYNC - 1);
  localparam logic [ROW_W-1:0] V_SYNC_BEG  = ROW_W'(ACTIVE_ROWS + V_FP);
  localparam logic [ROW_W-1:0] V_SYNC_LAST = ROW_W'(ACTIVE_ROWS + V_FP + V_SYNC - 1);

  // The output register is the last pipe stage, so the shift register only
  // supplies the remaining PIPE_DELAY-1 stages.
  localparam int DL_DEPTH = (PIPE_DELAY > 0) ? PIPE_DELAY - 1 : 0;

`ifdef VGA_TIMING_PATTERN_EN
  localparam int EXTRA_W = 1 + RGB_W;   // pattern select + pattern colour
`else
  localparam int EXTRA_W = 0;
`endif
  localparam int DL_W = 3 + EXTRA_W;

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             frame_start_reg;
  logic             col_last, row_last;
  logic             raw_hs, raw_vs, raw_act;
  logic [DL_W-1:0]  dl_in, dl_out;
  logic [RGB_W-1:0] rgb_src;
  logic             hs_out, vs_out, act_out;
  logic [RGB_W-1:0] rgb_out;

  assign col_last = (col_reg == COL_LAST);
  assign row_last = (row_reg == ROW_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_reg         <= '0;
      row_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= bus.i_Pix_En && col_last && row_last;
      if (bus.i_Pix_En) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
    end
  end

  assign raw_hs  = (col_reg >= H_SYNC_BEG) && (col_reg <= H_SYNC_LAST);
  assign raw_vs  = (row_reg >= V_SYNC_BEG) && (row_reg <= V_SYNC_LAST);
  assign raw_act = (col_reg < H_ACT_END) && (row_reg < V_ACT_END);

`ifdef VGA_TIMING_PATTERN_EN
  // Bar position tracked incrementally so no divide by BAR_W is needed.
  localparam int BAR_W  = ACTIVE_COLS / 8;
  localparam int BAR_CW = cnt_width(BAR_W);
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

  logic [BAR_CW-1:0] bar_cnt_reg;
  logic [2:0]        bar_idx_reg;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
    end else if (bus.i_Pix_En) begin
      if (col_last) begin
        bar_cnt_reg <= '0;
        bar_idx_reg <= '0;
      end else if (bar_cnt_reg == BAR_LAST) begin
        bar_cnt_reg <= '0;
        bar_idx_reg <= bar_idx_reg + 3'd1;
      end else begin
        bar_cnt_reg <= bar_cnt_reg + BAR_CW'(1);
      end
    end
  end

  assign dl_in = {bus.i_Pattern_Sel, {VIDEO_WIDTH{bar_idx_reg[2]}},
                  {VIDEO_WIDTH{bar_idx_reg[1]}}, {VIDEO_WIDTH{bar_idx_reg[0]}},
                  raw_hs, raw_vs, raw_act};
  // Pattern colour travels with the syncs; renderer RGB is already late.
  assign rgb_src = dl_out[DL_W-1] ? dl_out[DL_W-2 -: RGB_W]
                                  : {bus.i_Red_Video, bus.i_Grn_Video, bus.i_Blu_Video};
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = bus.i_Pattern_Sel;
  assign dl_in   = {raw_hs, raw_vs, raw_act};
  assign rgb_src = {bus.i_Red_Video, bus.i_Grn_Video, bus.i_Blu_Video};
`endif

  vga_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (DL_DEPTH)
  ) u_delay (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .en    (bus.i_Pix_En),
    .din   (dl_in),
    .dout  (dl_out)
  );

  generate
    if (PIPE_DELAY == 0) begin : g_comb_out
      assign hs_out  = dl_out[2];
      assign vs_out  = dl_out[1];
      assign act_out = dl_out[0];
      assign rgb_out = dl_out[0] ? rgb_src : '0;
    end else begin : g_reg_out
      logic             hs_reg, vs_reg, act_reg;
      logic [RGB_W-1:0] rgb_reg;

      // RGB captured on the tick that moves the counts to c belongs to pixel
      // c-PIPE_DELAY, the same pixel as the delayed active bit taken here.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          hs_reg  <= 1'b0;
          vs_reg  <= 1'b0;
          act_reg <= 1'b0;
          rgb_reg <= '0;
        end else if (bus.i_Pix_En) begin
          hs_reg  <= dl_out[2];
          vs_reg  <= dl_out[1];
          act_reg <= dl_out[0];
          rgb_reg <= dl_out[0] ? rgb_src : '0;
        end
      end

      assign hs_out  = hs_reg;
      assign vs_out  = vs_reg;
      assign act_out = act_reg;
      assign rgb_out = rgb_reg;
    end
  endgenerate

  assign bus.o_Col_Count   = col_reg;
  assign bus.o_Row_Count   = row_reg;
  assign bus.o_Frame_Start = frame_start_reg;
  assign bus.o_HSync       = hs_out ? H_SYNC_POL : ~H_SYNC_POL;
  assign bus.o_VSync       = vs_out ? V_SYNC_POL : ~V_SYNC_POL;
  assign bus.o_Active      = act_out;
  assign bus.o_Red_Video   = rgb_out[RGB_W-1 -: VIDEO_WIDTH];
  assign bus.o_Grn_Video   = rgb_out[VIDEO_WIDTH +: VIDEO_WIDTH];
  assign bus.o_Blu_Video   = rgb_out[0 +: VIDEO_WIDTH];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Random pixel-enable / RGB stimulus on a shrunken timing set (48x21 total)
// checked every clock against an arithmetic model: the number of enabled
// ticks since reset t gives counts (t mod cols, t/cols mod rows) and all
// delayed outputs describe pixel t-PIPE_DELAY.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int   VW  = 3;
  localparam int   AC  = 32, HFP = 4, HS = 6, HBP = 6;
  localparam int   AR  = 12, VFP = 2, VS = 3, VBP = 4;
  localparam logic HPOL = SYNC_ACTIVE_LOW;
  localparam logic VPOL = SYNC_ACTIVE_HIGH;
  localparam int   D   = 2;
  localparam int   TC  = AC + HFP + HS + HBP;
  localparam int   TR  = AR + VFP + VS + VBP;
  localparam int   FRAME = TC * TR;
  localparam int   CW  = cnt_width(TC);
  localparam int   RW  = cnt_width(TR);
  localparam int   RGB_W = 3 * VW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.VIDEO_WIDTH(VW), .COL_W(CW), .ROW_W(RW)) bus ();

  vga_timing_gen #(
    .VIDEO_WIDTH (VW),
    .ACTIVE_COLS (AC), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .ACTIVE_ROWS (AR), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_SYNC_POL  (HPOL),
    .V_SYNC_POL  (VPOL),
    .PIPE_DELAY  (D)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  int               n_cmp = 0;
  int               n_bad = 0;
  int               t     = 0;
  logic [RGB_W-1:0] last_rgb = '0;
  logic [RGB_W-1:0] drv_rgb  = '0;
  logic             fs_exp   = 1'b0;
  logic             pat_sel  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t t=%0d got=%0h exp=%0h", tag, $time, t, got, exp);
    end
  endtask

  // {hsync_active, vsync_active, data_enable} of pixel p; nothing before 0.
  function automatic logic [2:0] raw_of(input int p);
    int c, r;
    if (p < 0) return 3'b000;
    c = p % TC;
    r = (p / TC) % TR;
    return {(c >= AC + HFP) && (c < AC + HFP + HS),
            (r >= AR + VFP) && (r < AR + VFP + VS),
            (c < AC) && (r < AR)};
  endfunction

  function automatic logic [RGB_W-1:0] bar_rgb(input int p);
    logic [2:0] b;
    b = 3'((p % TC) / (AC / 8));
    return {{VW{b[2]}}, {VW{b[1]}}, {VW{b[0]}}};
  endfunction

  task automatic check_outputs(input string ph);
    logic [2:0]       rw;
    logic [RGB_W-1:0] src, rgb_e;
    rw  = raw_of(t - D);
    src = (D == 0) ? drv_rgb : last_rgb;
`ifdef VGA_TIMING_PATTERN_EN
    if (pat_sel) src = bar_rgb(t - D);
`endif
    rgb_e = rw[0] ? src : '0;
    check_eq({ph, ":count"}, 32'({bus.o_Col_Count, bus.o_Row_Count}),
             32'({CW'(t % TC), RW'((t / TC) % TR)}));
    check_eq({ph, ":frame_start"}, 32'(bus.o_Frame_Start), 32'(fs_exp));
    check_eq({ph, ":sync"}, 32'({bus.o_HSync, bus.o_VSync}),
             32'({rw[2] ? HPOL : ~HPOL, rw[1] ? VPOL : ~VPOL}));
    check_eq({ph, ":active"}, 32'(bus.o_Active), 32'(rw[0]));
    check_eq({ph, ":rgb"}, 32'({bus.o_Red_Video, bus.o_Grn_Video, bus.o_Blu_Video}),
             32'(rgb_e));
  endtask

  // One clock: drive inputs, take the edge, advance the model, check at +1.
  task automatic step(input logic en, input string ph);
    drv_rgb = RGB_W'($urandom);
    bus.i_Pix_En = en;
    {bus.i_Red_Video, bus.i_Grn_Video, bus.i_Blu_Video} = drv_rgb;
    @(posedge clk);
    fs_exp = 1'b0;
    if (!rst_n) begin
      t = 0;
    end else if (en) begin
      t++;
      last_rgb = drv_rgb;
      fs_exp   = (t % FRAME == 0);
    end
    #1;
    check_outputs(ph);
  endtask

  // Assert reset between edges, check it acted with no clock edge, hold,
  // then release on a falling edge.
  task automatic apply_reset(input int cycles, input string ph);
    #3;
    rst_n   = 1'b0;
    pat_sel = 1'($urandom);
    bus.i_Pattern_Sel = pat_sel;
    t      = 0;
    fs_exp = 1'b0;
    #2;
    check_outputs({ph, ":async"});
    repeat (cycles) step(1'($urandom), ph);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic report(input string ph, input int cycles);
    $display("phase %-9s cycles=%0d compared=%0d mismatched=%0d", ph, cycles, n_cmp, n_bad);
  endtask

  initial begin
    bus.i_Pix_En      = 1'b1;
    bus.i_Pattern_Sel = 1'b0;
    {bus.i_Red_Video, bus.i_Grn_Video, bus.i_Blu_Video} = '0;
    @(posedge clk);
    #1;

    apply_reset(4, "reset");
    report("reset", 4);

    for (int i = 0; i < 2 * FRAME + 50; i++) step(1'b1, "full");
    report("full", 2 * FRAME + 50);

    for (int i = 0; i < 2 * FRAME + 100; i++) step(1'(i % 2), "toggle");
    report("toggle", 2 * FRAME + 100);

    for (int i = 0; i < 3000; i++) step(($urandom % 4) != 0, "random");
    report("random", 3000);

    // Run to a mid-frame position, then reset asynchronously.
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((t % TC == 20) && ((t / TC) % TR == 7)) break;
      step(1'b1, "seek");
    end
    apply_reset(2, "midreset");
    for (int i = 0; i < 3 * TC; i++) step(1'b1, "restart");
    report("midreset", 3 * TC + 2);

    apply_reset(1, "reset2");
    for (int i = 0; i < FRAME + 10; i++) step(($urandom % 3) != 0, "final");
    report("final", FRAME + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator that replaces the fixed sync-pulse and sync-porch pair with one block. It supports any resolution or porch set, configurable sync polarity and a pixel clock-enable. It includes a pixel-enable-driven delay line, so a renderer with known latency receives aligned syncs and blanked RGB. It sits between the game/render logic and the VGA pins.

Parameters:
VIDEO_WIDTH, 3, bits per colour channel
ACTIVE_COLS, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
ACTIVE_ROWS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, active level of o_HSync
V_SYNC_POL, 0, active level of o_VSync
PIPE_DELAY, 2, pixel-enable cycles from o_Col/Row_Count to sync/video outputs (0..15)

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Pix_En  in  1  pixel tick; all state advances only when high
i_Pattern_Sel  in  1  select internal test pattern (ignored without macro)
i_Red_Video  in  VIDEO_WIDTH  renderer red for the pixel at counts PIPE_DELAY ticks earlier
i_Grn_Video  in  VIDEO_WIDTH  renderer green
i_Blu_Video  in  VIDEO_WIDTH  renderer blue
o_Col_Count  out  clog2(TOTAL_COLS)  current column
o_Row_Count  out  clog2(TOTAL_ROWS)  current row
o_Frame_Start  out  1  one-clock pulse when counters wrap to (0,0)
o_HSync  out  1  delayed hsync
o_VSync  out  1  delayed vsync
o_Active  out  1  delayed data-enable
o_Red_Video / o_Grn_Video / o_Blu_Video  out  VIDEO_WIDTH each  blanked, aligned colour

Behaviour:
- Derived values: TOTAL_COLS = ACTIVE_COLS+H_FP+H_SYNC+H_BP (800); TOTAL_ROWS = ACTIVE_ROWS+V_FP+V_SYNC+V_BP (525).
- Column counter:
  - Increments on each i_Clk edge with i_Pix_En=1.
  - Wraps TOTAL_COLS-1 -> 0.
  - On wrap, row increments; row wraps TOTAL_ROWS-1 -> 0.
- Raw hsync: active while col in [ACTIVE_COLS+H_FP, ACTIVE_COLS+H_FP+H_SYNC). Raw vsync uses the same rule on row.
- Raw active = col<ACTIVE_COLS AND row<ACTIVE_ROWS.
- Delay line:
  - Raw hsync, vsync and active enter a PIPE_DELAY-deep shift register that shifts only on i_Pix_En.
  - PIPE_DELAY=0 means combinational from the registered counts.
  - Outputs hold while i_Pix_En=0.
- Video path:
  - On i_Pix_En, RGB is registered into the output stage together with the delayed active bit.
  - Output RGB = input RGB when delayed active=1, else 0.
- Polarity: o_HSync = H_SYNC_POL when sync is active, ~H_SYNC_POL otherwise. o_VSync is the same with V_SYNC_POL.
- o_Frame_Start: registered; high for exactly one i_Clk cycle, the cycle after the i_Pix_En edge that wraps (TOTAL_COLS-1, TOTAL_ROWS-1) -> (0,0). No pulse on reset release.
- Reset (asynchronous, i_Rst_L=0):
  - Counts are 0; o_Frame_Start, o_Active and RGB are 0.
  - Syncs are inactive.
  - Delay line is filled with the inactive/blank state.
  - Mid-frame reset takes effect immediately and restarts at (0,0).
- i_Pix_En held high (25 MHz i_Clk): line = 800 clocks, frame = 420000 clocks.

Optional Feature:
VGA_TIMING_PATTERN_EN
- Defined:
  - When i_Pattern_Sel=1, internal 8-bar colour pattern replaces i_*_Video at the input of the delay path, so it is aligned identically.
  - Bar width BAR_W = ACTIVE_COLS/8, tracked by a sub-counter (no divider).
  - Bar index b = 0..7; R = {VIDEO_WIDTH{b[2]}}, G = {VIDEO_WIDTH{b[1]}}, B = {VIDEO_WIDTH{b[0]}}.
- Undefined: i_Pattern_Sel is ignored and no pattern logic is synthesised.

Decomposition:
- Shared package vga_timing_pkg:
  - Default 640x480 timing constants.
  - Polarity constants.
  - Function computing the counter width (clog2).
- One natural sub-module: vga_delay_line, a parametrised width/depth enable-gated shift register used for the sync/active bits and, if desired, the pattern RGB.

Test Plan:
1. Reset (defaults, i_Pix_En=1) -> counts 0, o_HSync=1, o_VSync=1, o_Active=0, RGB=0, o_Frame_Start=0.
2. Hsync timing -> o_HSync low for 96 clocks starting when o_Col_Count=658; period 800 clocks.
3. Vsync timing -> o_VSync low for 1600 clocks across rows 490-491 (offset by 2 pixels); o_Frame_Start period 420000 clocks.
4. Blanking, i_Red_Video=7 constant:
   - o_Red_Video=7 for exactly 640 clocks per line in rows 0-479.
   - 0 elsewhere, including all of rows 480-524.
5. i_Pix_En toggling every other clock -> line = 1600 clocks; all outputs stable on disabled cycles.
6. i_Rst_L pulsed low at col 300 row 100 -> outputs reach reset values with no clock edge; restart at (0,0). With VGA_TIMING_PATTERN_EN and i_Pattern_Sel=1:
   - Pixels 0-79 black.
   - Pixels 80-159 blue=7.
   - Pixels 560-639 all channels 7.
